// File: rtl/seq_step_fsm.sv
// Moore sequence checker: walks go/adv handshake through NSTEP steps,
// with per-step dwell timeout, debounced recovery and sticky error count.
module seq_step_fsm #(
  parameter int NSTEP   = 2,
  parameter int TIMEOUT = 15,
  parameter int RECOVER = 1,
  parameter int CNT_W   = 4,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             adv,
  input  logic             clr,
  output logic [NSTEP-1:0] step,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int IW = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  localparam logic [IW-1:0] LAST =
    IW'(NSTEP - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] RC_LAST =
    CNT_W'(RECOVER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_ERR
  } state_t;

  state_t           st, st_d;
  logic [IW-1:0]    idx, idx_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             fin;
  logic             hold;

  logic [NSTEP-1:0] step_d;
  logic             ent;
  logic             flag_d;
  logic [ERR_W-1:0] ecnt_base, ecnt_d;

  always_comb begin
    st_d  = st;
    idx_d = idx;
    cnt_d = cnt;
    fin   = 1'b0;
    hold  = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (go) begin
          cnt_d = '0;
          idx_d = '0;
          st_d  = adv ? S_STEP : S_ERR;
        end
      end
      S_STEP: begin
        if (idx != LAST) begin
          if (!adv) begin
            hold = 1'b1;
          end else if (go) begin
            idx_d = idx + 1'b1;
            cnt_d = '0;
          end else begin
            st_d  = S_ERR;
            cnt_d = '0;
          end
        end else begin
          if (adv) begin
            hold = 1'b1;
          end else if (go) begin
            st_d = S_IDLE;
            fin  = 1'b1;
          end else begin
            st_d  = S_ERR;
            cnt_d = '0;
          end
        end
        // explicit moves already resolved; timeout only cuts a hold
        if (hold) begin
          if (TIMEOUT > 0 && cnt == TO_LAST) begin
            st_d  = S_ERR;
            cnt_d = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      S_ERR: begin
        if (go) begin
          cnt_d = '0;
        end else if (cnt == RC_LAST) begin
          st_d  = S_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        st_d  = S_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // outputs decode the next state so they align with the state register
  always_comb begin
    step_d = '0;
    if (st_d == S_STEP)
      step_d = NSTEP'(1) << idx_d;
    ent       = (st_d == S_ERR) && (st != S_ERR);
    flag_d    = ent | (err_flag & ~clr);
    ecnt_base = clr ? '0 : err_cnt;
    ecnt_d    = ecnt_base;
    if (ent && !(&ecnt_base))
      ecnt_d = ecnt_base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      step     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else begin
      st       <= st_d;
      idx      <= idx_d;
      cnt      <= cnt_d;
      step     <= step_d;
      busy     <= (st_d == S_STEP);
      done     <= fin;
      err      <= (st_d == S_ERR);
      err_flag <= flag_d;
      err_cnt  <= ecnt_d;
    end
  end

endmodule

// File: tb/tb_seq_step_fsm.sv
// Bench for seq_step_fsm: vector table, hand corner sequences,
// then random traffic against a step-numbered reference model.
module tb_seq_step_fsm;

  localparam int N   = 3;
  localparam int TO  = 8;
  localparam int RC  = 4;
  localparam int EW  = 8;
  localparam int W   = N + 4 + EW;
  localparam int ERS = N + 1;

  logic          clk = 1'b0;
  logic          rst, go, adv, clr;
  logic [N-1:0]  step;
  logic          busy, done, err, err_flag;
  logic [EW-1:0] err_cnt;

  seq_step_fsm #(
    .NSTEP(N), .TIMEOUT(TO), .RECOVER(RC),
    .CNT_W(4), .ERR_W(EW)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .adv(adv), .clr(clr),
    .step(step), .busy(busy), .done(done), .err(err),
    .err_flag(err_flag), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  // model: ms = 0 idle, 1..N step number, N+1 error
  int ms = 0, dwell = 0, zeros = 0, m_cnt = 0;
  bit m_flag = 0, m_done = 0;

  task automatic model(input bit r, g, a, c);
    int nx;
    bit stay;
    if (r) begin
      ms = 0; dwell = 0; zeros = 0;
      m_cnt = 0; m_flag = 0; m_done = 0;
      return;
    end
    nx = ms;
    m_done = 0;
    if (ms == 0) begin
      if (g) nx = a ? 1 : ERS;
    end else if (ms == ERS) begin
      if (g) zeros = 0;
      else begin
        zeros++;
        if (zeros == RC) nx = 0;
      end
    end else begin
      stay = (ms < N) ? !a : a;
      if (!stay) begin
        if (ms < N) nx = g ? ms + 1 : ERS;
        else begin
          nx = g ? 0 : ERS;
          m_done = g;
        end
      end else if (TO > 0 && dwell == TO) nx = ERS;
      else dwell++;
    end
    if (c) begin m_cnt = 0; m_flag = 0; end
    if (nx == ERS && ms != ERS) begin
      zeros = 0;
      m_flag = 1;
      if (m_cnt < (1 << EW) - 1) m_cnt++;
    end
    if (nx >= 1 && nx <= N && nx != ms) dwell = 1;
    ms = nx;
  endtask

  function automatic logic [W-1:0] exp_v();
    logic [N-1:0] s;
    s = '0;
    if (ms >= 1 && ms <= N) s[ms-1] = 1'b1;
    return {s, (ms >= 1 && ms <= N), m_done, (ms == ERS),
            m_flag, m_cnt[EW-1:0]};
  endfunction

  function automatic logic [W-1:0] got_v();
    return {step, busy, done, err, err_flag, err_cnt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic apply(input bit r, g, a, c);
    rst = r; go = g; adv = a; clr = c;
    model(r, g, a, c);
    @(posedge clk);
    #1;
  endtask

  task automatic mcyc(input bit r, g, a, c, input string nm);
    apply(r, g, a, c);
    chk(nm, 32'(got_v()), 32'(exp_v()));
  endtask

  typedef struct {
    bit r, g, a, c;
    logic [N-1:0] s;
    bit b, d, e, f;
    logic [EW-1:0] n;
  } vec_t;

  vec_t tbl[17];

  initial begin
    rst = 1'b1; go = 1'b0; adv = 1'b0; clr = 1'b0;

    tbl[0]  = '{1,1,0,0, 3'b000, 0,0,0,0, 8'd0};
    tbl[1]  = '{1,0,1,0, 3'b000, 0,0,0,0, 8'd0};
    tbl[2]  = '{0,1,1,0, 3'b001, 1,0,0,0, 8'd0};
    tbl[3]  = '{0,1,1,0, 3'b010, 1,0,0,0, 8'd0};
    tbl[4]  = '{0,1,1,0, 3'b100, 1,0,0,0, 8'd0};
    tbl[5]  = '{0,1,0,0, 3'b000, 0,1,0,0, 8'd0};
    tbl[6]  = '{0,0,0,0, 3'b000, 0,0,0,0, 8'd0};
    tbl[7]  = '{0,1,1,0, 3'b001, 1,0,0,0, 8'd0};
    tbl[8]  = '{0,1,1,0, 3'b010, 1,0,0,0, 8'd0};
    tbl[9]  = '{0,0,1,0, 3'b000, 0,0,1,1, 8'd1};
    tbl[10] = '{0,0,1,0, 3'b000, 0,0,1,1, 8'd1};
    tbl[11] = '{0,0,0,0, 3'b000, 0,0,1,1, 8'd1};
    tbl[12] = '{0,1,1,0, 3'b000, 0,0,1,1, 8'd1};
    tbl[13] = '{0,0,0,0, 3'b000, 0,0,1,1, 8'd1};
    tbl[14] = '{0,0,1,0, 3'b000, 0,0,1,1, 8'd1};
    tbl[15] = '{0,0,0,0, 3'b000, 0,0,1,1, 8'd1};
    tbl[16] = '{0,0,0,0, 3'b000, 0,0,0,1, 8'd1};

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].r, tbl[i].g, tbl[i].a, tbl[i].c);
      chk($sformatf("tbl%0d", i), 32'(got_v()),
          32'({tbl[i].s, tbl[i].b, tbl[i].d,
               tbl[i].e, tbl[i].f, tbl[i].n}));
    end

    // dwell timeout in STEP1
    mcyc(0, 1, 1, 0, "to_enter");
    for (int i = 0; i < 7; i++)
      mcyc(0, 1'($urandom), 0, 0, "to_hold");
    chk("to_still_s1", 32'(step), 32'(3'b001));
    mcyc(0, 1, 0, 0, "to_fire");
    chk("to_err", 32'(err), 32'd1);
    for (int i = 0; i < RC; i++)
      mcyc(0, 0, 1'($urandom), 0, "to_rec");
    chk("to_idle", 32'({busy, err}), 32'd0);

    // advance on the last allowed dwell cycle beats the timeout
    mcyc(0, 1, 1, 0, "adv_enter");
    for (int i = 0; i < 7; i++)
      mcyc(0, 1, 0, 0, "adv_hold");
    mcyc(0, 1, 1, 0, "adv_take");
    chk("adv_step2", 32'(step), 32'(3'b010));
    chk("adv_noerr", 32'(err), 32'd0);
    mcyc(0, 1, 1, 0, "adv_s3");
    mcyc(0, 1, 0, 0, "adv_done");
    chk("adv_done_pulse", 32'(done), 32'd1);

    // saturating error count, then clear
    for (int i = 0; i < 300; i++) begin
      mcyc(0, 1, 0, 0, "sat_err");
      for (int j = 0; j < RC; j++)
        mcyc(0, 0, 0, 0, "sat_rec");
    end
    chk("sat_cnt", 32'(err_cnt), 32'd255);
    mcyc(0, 0, 0, 1, "clr_idle");
    chk("clr_flag", 32'(err_flag), 32'd0);
    chk("clr_cnt", 32'(err_cnt), 32'd0);
    mcyc(0, 1, 0, 1, "clr_entry");
    chk("clr_entry_cnt", 32'(err_cnt), 32'd1);
    chk("clr_entry_flag", 32'(err_flag), 32'd1);
    for (int j = 0; j < RC; j++)
      mcyc(0, 0, 0, 0, "clr_rec");

    // reset aborts in STEP3 and in ERROR
    for (int i = 0; i < N; i++)
      mcyc(0, 1, 1, 0, "mid_walk");
    chk("mid_s3", 32'(step), 32'(3'b100));
    mcyc(1, 1, 0, 0, "mid_rst_s3");
    chk("mid_rst_s3_zero", 32'(got_v()), 32'd0);
    mcyc(0, 1, 0, 0, "mid_err");
    mcyc(1, 0, 0, 1, "mid_rst_err");
    chk("mid_rst_err_zero", 32'(got_v()), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      mcyc(($urandom_range(63) == 0),
           ($urandom_range(7) != 0),
           1'($urandom),
           ($urandom_range(15) == 0), "rand");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule

// File: doc/seq_step_fsm.md
# seq_step_fsm

Parametrised Moore sequence-checker FSM that walks a control handshake through NSTEP progress states, driven by two qualifier inputs `go` and `adv`. It adds three mechanisms: a per-step dwell timeout, a debounced error recovery, and sticky error reporting with a saturating count. It sits between a bus-side sequencer and its datapath, and flags protocol violations to the status block.

## Interface
- `NSTEP`, default 2: number of progress states (STEP1..STEPn); legal range 2..8.
- `TIMEOUT`, default 15: maximum dwell cycles in any STEP state; 0 disables the timeout; must fit in `CNT_W` bits.
- `RECOVER`, default 1: consecutive `go`=0 cycles required to leave ERROR; legal range 1..2^`CNT_W`-1.
- `CNT_W`, default 4: width of the shared dwell/recover counter.
- `ERR_W`, default 8: width of the error counter.
- `clk`, input, 1: single clock; all flops update on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `go`, input, 1: sequence-enable qualifier.
- `adv`, input, 1: advance qualifier.
- `clr`, input, 1: clears `err_flag` and `err_cnt`.
- `step`, output, `NSTEP`: one-hot current step; bit k-1 is high in STEPk; all zero in IDLE and ERROR.
- `busy`, output, 1: high in any STEP state.
- `done`, output, 1: one-cycle pulse when the last step completes back to IDLE.
- `err`, output, 1: high while in ERROR.
- `err_flag`, output, 1: sticky; set on each ERROR entry.
- `err_cnt`, output, `ERR_W`: count of ERROR entries; saturates at all-ones.

## Operation
- State set: IDLE, STEP1..STEPn (n=`NSTEP`), ERROR. Encoding is free.
- All outputs are registered. They load from the next-state decode, so they are valid in the same cycle the state register holds that state. No combinational path from inputs to outputs.
- IDLE:
  - `go`=0: stay.
  - `go`=1, `adv`=1: STEP1.
  - `go`=1, `adv`=0: ERROR.
- STEPk, k<n:
  - `adv`=0: stay.
  - `adv`=1, `go`=1: STEPk+1.
  - `adv`=1, `go`=0: ERROR.
- STEPn:
  - `adv`=1: stay.
  - `adv`=0, `go`=1: IDLE; assert `done` for one cycle.
  - `adv`=0, `go`=0: ERROR.
- Timeout (`TIMEOUT`>0):
  - The counter clears on entry to any STEP state and increments each cycle the state is held.
  - If a STEP state would stay while the counter equals `TIMEOUT`-1, the next state is ERROR. Dwell is therefore at most `TIMEOUT` cycles.
  - Explicit transition conditions take precedence over the timeout.
- ERROR:
  - The counter clears on entry.
  - Each cycle with `go`=0 increments the counter; any `go`=1 clears it.
  - When `go`=0 and the counter equals `RECOVER`-1, the next state is IDLE. With `RECOVER`=1, `go`=0 exits immediately.
  - `adv` is ignored in ERROR.
- Error reporting:
  - Each ERROR entry sets `err_flag` and increments `err_cnt`, saturating.
  - `clr` zeroes both, but not `err`.
  - `clr` in the same cycle as an ERROR entry: clear first, then count, giving `err_flag`=1 and `err_cnt`=1.
- Reset:
  - `rst` high gives IDLE and zeroes the counter.
  - All outputs reset to 0: `step`, `busy`, `done`, `err`, `err_flag`, `err_cnt`.
  - Reset mid-sequence or in ERROR aborts without asserting `done`.
  - `rst` overrides `clr` and all inputs.

## Timing
- Latency is one cycle from input sample to state/output change.
- `done` is high exactly in the first IDLE cycle after STEPn.
- A full pass with `adv` asserted on consecutive cycles:
  - IDLE → STEP1 … STEPn takes n cycles.
  - Leaving STEPn takes ≥1 further cycle with `adv`=0.
- Error is reported in the cycle after the offending sample; `err`, `err_flag` and `err_cnt` all update in that same cycle.
- Minimum ERROR residence is `RECOVER` cycles.

## Test plan
Configuration: `NSTEP`=3, `TIMEOUT`=8, `RECOVER`=4.

1. **Reset:** assert `rst` for 2 cycles with random `go`/`adv` → all outputs 0, state IDLE. Then `go`=`adv`=1 for 1 cycle → `step`=001, `busy`=1.
2. **Good pass:** `go`=1, `adv`=1 for 3 cycles, then `adv`=0 → `step` reads 001, 010, 100, then 000; `done`=1 for exactly 1 cycle; `err_cnt`=0.
3. **Protocol error:** in STEP2, drive `adv`=1, `go`=0 → next cycle `err`=1, `err_flag`=1, `err_cnt`=1. Then `go`=0, 0, 1, 0, 0, 0, 0 → IDLE is reached only after the final 4 consecutive zeros.
4. **Timeout:** enter STEP1 and hold `adv`=0 → ERROR after 8 STEP1 cycles. Repeat, asserting `adv`=`go`=1 in dwell cycle 8 → STEP2 is taken, no error.
5. **Counter and clear:** force 300 errors with `ERR_W`=8 → `err_cnt` saturates at 255. Pulse `clr` while not in ERROR → `err_flag`=0, `err_cnt`=0. Pulse `clr` on an ERROR-entry cycle → `err_cnt`=1.
6. **Reset mid-op:** assert `rst` in STEP3 and in ERROR → IDLE next cycle, `done`=0, `err`=0, `err_cnt`=0.
